// File: rtl/word_cmp_pkg.sv
// Shared definitions for the sequential multi-word comparator: relation
// mode codes, FSM state encoding and the mode-selected result mux.
package word_cmp_pkg;

  // Relation selected by in_mode, latched on the first beat of an operand.
  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_NE = 2'b01;
  localparam logic [1:0] MODE_LT = 2'b10;
  localparam logic [1:0] MODE_GT = 2'b11;

  // Controller states. The encoding is visible on the top-level state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Picks the single-bit result for a mode from the raw relation flags.
  function automatic logic sel_result(
    input logic [1:0] mode,
    input logic       eq,
    input logic       lt,
    input logic       gt
  );
    logic r;
    case (mode)
      MODE_EQ: r = eq;
      MODE_NE: r = ~eq;
      MODE_LT: r = lt;
      MODE_GT: r = gt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/word_cmp_cell.sv
// One-word unsigned compare cell: reports equality and A>B for a single
// word pair. A<B is implied by ~eq & ~gt, so it is not produced here.
module word_cmp_cell #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt
);

  // Pure combinational relation of the two words.
  always_comb begin
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/word_cmp_seq.sv
// Sequential comparator for multi-word unsigned operands streamed
// most-significant word first. The first differing word decides the
// relation; later words are only counted. The result is registered and
// held until the consumer acknowledges it.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// the producer holds in_a/in_b/in_last/in_mode stable while in_ready is low.
// A result is offered while out_valid is high and is consumed on the edge
// where out_valid && out_ack; out_ack with out_valid low has no effect.
module word_cmp_seq
  import word_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [1:0]                   in_mode,
  output logic                         out_valid,
  input  logic                         out_ack,
  output logic                         out_s,
  output logic                         out_eq,
  output logic                         out_lt,
  output logic                         out_gt,
  output logic [$clog2(WORDS+1)-1:0]   out_count,
  output logic                         out_err,
  output state_t                       state
);

  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(WORDS);

  // Per-word relation of the current beat.
  logic word_eq;
  logic word_gt;

  word_cmp_cell #(
    .WIDTH (WIDTH)
  ) u_cell (
    .a  (in_a),
    .b  (in_b),
    .eq (word_eq),
    .gt (word_gt)
  );

  // Running state for the operand being streamed.
  logic [1:0]    mode_q;
  logic          decided_q;
  logic          gt_q;
  logic          lt_q;
  logic [CW-1:0] count_q;

  // Values the running state takes if the current beat is accepted.
  logic          accept;
  logic [1:0]    mode_n;
  logic          base_decided;
  logic          decided_n;
  logic          gt_n;
  logic          lt_n;
  logic [CW-1:0] count_n;
  logic          end_n;
  logic          err_n;

  assign in_ready = (state != ST_DONE);
  assign accept   = in_valid && in_ready;

  // Next running state for an accepted beat; the first beat restarts it.
  always_comb begin
    mode_n       = mode_q;
    base_decided = decided_q;
    gt_n         = gt_q;
    lt_n         = lt_q;
    count_n      = count_q + CW'(1);
    if (state == ST_IDLE) begin
      mode_n       = in_mode;
      base_decided = 1'b0;
      gt_n         = 1'b0;
      lt_n         = 1'b0;
      count_n      = CW'(1);
    end
    decided_n = base_decided;
    if (!base_decided && !word_eq) begin
      decided_n = 1'b1;
      gt_n      = word_gt;
      lt_n      = ~word_gt;
    end
    end_n = in_last || (count_n == COUNT_MAX);
    err_n = !in_last && (count_n == COUNT_MAX);
  end

  // Controller FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_EQ;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      count_q   <= '0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_eq    <= 1'b0;
      out_lt    <= 1'b0;
      out_gt    <= 1'b0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            mode_q    <= mode_n;
            decided_q <= decided_n;
            gt_q      <= gt_n;
            lt_q      <= lt_n;
            count_q   <= count_n;
            if (end_n) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_eq    <= ~decided_n;
              out_lt    <= lt_n;
              out_gt    <= gt_n;
              out_s     <= sel_result(mode_n, ~decided_n, lt_n, gt_n);
              out_count <= count_n;
              out_err   <= err_n;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          if (out_ack) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_gt    <= 1'b0;
            out_count <= '0;
            out_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_cmp_seq.sv
// Directed bench for word_cmp_seq. Stimulus pushes the hand-computed result
// into exp_q; a monitor pops and compares whenever out_valid rises.
module tb_word_cmp_seq;
  import word_cmp_pkg::*;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int W     = 5 + CW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [1:0]       in_mode = MODE_EQ;
  logic             out_ack = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_s;
  logic             out_eq;
  logic             out_lt;
  logic             out_gt;
  logic [CW-1:0]    out_count;
  logic             out_err;
  state_t           state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic [W-1:0] act;

  assign act = {out_s, out_eq, out_lt, out_gt, out_count, out_err};

  // Clock
  always #5 clk = ~clk;

  word_cmp_seq #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .out_s     (out_s),
    .out_eq    (out_eq),
    .out_lt    (out_lt),
    .out_gt    (out_gt),
    .out_count (out_count),
    .out_err   (out_err),
    .state     (state)
  );

  function automatic logic [W-1:0] pack(input logic s, input logic eq, input logic lt,
                                        input logic gt, input int cnt, input logic err);
    logic [CW-1:0] c;
    c = CW'(cnt);
    return {s, eq, lt, gt, c, err};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Scoreboard monitor: one comparison per presented result.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %h want none", act);
        end else begin
          check("result", act, exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Drivers: all called just after a rising edge.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic last, input logic [1:0] mode);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_mode  = mode;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic last, input logic [1:0] mode);
    int n;
    drive(a, b, last, mode);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got in_ready=0 want 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_ack();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got out_valid=0 want 1 within 50 cycles");
    end
    @(posedge clk);
    #1 out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no end want end before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Directed sequence
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outputs", act, '0);
    check_bit("reset_ready", in_ready, 1'b1);
    check_bit("reset_valid", out_valid, 1'b0);
    check("reset_state", W'(state), W'(ST_IDLE));

    // out_ack while idle has no effect
    @(posedge clk);
    #1 out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
    @(negedge clk);
    check_bit("idle_ack_ready", in_ready, 1'b1);
    check_bit("idle_ack_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // EQ, four equal words
    exp_q.push_back(pack(1, 1, 0, 0, 4, 0));
    send(8'h12, 8'h12, 1'b0, MODE_EQ);
    send(8'h34, 8'h34, 1'b0, MODE_EQ);
    send(8'h56, 8'h56, 1'b0, MODE_EQ);
    check_bit("no_early_valid", out_valid, 1'b0);
    send(8'h78, 8'h78, 1'b1, MODE_EQ);
    @(negedge clk);
    check_bit("latency_valid", out_valid, 1'b1);
    check_bit("done_ready", in_ready, 1'b0);
    do_ack();

    // LT decided by the most significant word
    exp_q.push_back(pack(1, 0, 1, 0, 2, 0));
    send(8'h10, 8'h11, 1'b0, MODE_LT);
    send(8'hFF, 8'h00, 1'b1, MODE_GT);
    do_ack();

    // GT single word, then a mode change while the result is held
    exp_q.push_back(pack(1, 0, 0, 1, 1, 0));
    send(8'hFF, 8'hFE, 1'b1, MODE_GT);
    in_mode = MODE_EQ;
    repeat (3) @(negedge clk);
    check_bit("mode_change_s", out_s, 1'b1);
    do_ack();

    // GT decided by the second word after an equal MSW
    exp_q.push_back(pack(1, 0, 0, 1, 2, 0));
    send(8'h12, 8'h12, 1'b0, MODE_GT);
    send(8'h80, 8'h7F, 1'b1, MODE_GT);
    do_ack();

    // EQ mode with a difference in the last word
    exp_q.push_back(pack(0, 0, 1, 0, 3, 0));
    send(8'h01, 8'h01, 1'b0, MODE_EQ);
    send(8'h02, 8'h02, 1'b0, MODE_EQ);
    send(8'h03, 8'h04, 1'b1, MODE_EQ);
    do_ack();

    // NE forced end after WORDS beats; beat 5 is held then starts a new operand
    exp_q.push_back(pack(0, 1, 0, 0, 4, 1));
    exp_q.push_back(pack(1, 0, 1, 0, 1, 0));
    send(8'hAA, 8'hAA, 1'b0, MODE_NE);
    send(8'hAA, 8'hAA, 1'b0, MODE_NE);
    send(8'hAA, 8'hAA, 1'b0, MODE_NE);
    send(8'hAA, 8'hAA, 1'b0, MODE_NE);
    drive(8'h01, 8'h02, 1'b1, MODE_NE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", act, pack(0, 1, 0, 0, 4, 1));
      check_bit("hold_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1 out_ack = 1'b1;
    @(negedge clk);
    check_bit("ack_cycle_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 out_ack = 1'b0;
    @(negedge clk);
    check_bit("after_ack_ready", in_ready, 1'b1);
    check_bit("after_ack_valid", out_valid, 1'b0);
    check("after_ack_zeroed", act, '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check_bit("beat5_result_valid", out_valid, 1'b1);
    do_ack();

    // Reset in RUN discards the partial operand
    send(8'h11, 8'h22, 1'b0, MODE_EQ);
    send(8'h33, 8'h44, 1'b0, MODE_EQ);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", act, '0);
    check_bit("midrun_reset_ready", in_ready, 1'b1);
    check_bit("midrun_reset_valid", out_valid, 1'b0);
    check("midrun_reset_state", W'(state), W'(ST_IDLE));
    @(posedge clk);
    #1;
    exp_q.push_back(pack(1, 1, 0, 0, 1, 0));
    send(8'h00, 8'h00, 1'b1, MODE_EQ);
    do_ack();

    repeat (3) @(negedge clk);
    check("queue_drain", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
